// File: rtl/pc_redirect_ctrl_if.sv
// Signal bundle between the EX-stage branch logic / hazard unit and the fetch PC controller.
// No handshake: stall, PcSel and BrPC are sampled at every rising edge; outputs are valid every cycle.
interface pc_redirect_ctrl_if #(
  parameter int PC_W = 9
);
  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] Cur_PC;
  logic [PC_W-1:0] PC_Four;
  logic            IF_ID_Flush;
  logic            ID_EX_Flush;
  logic            misalign_err;
  logic [15:0]     redirect_cnt;
  logic [0:0]      fsm_state;

  modport master (
    output stall, PcSel, BrPC,
    input  Cur_PC, PC_Four, IF_ID_Flush, ID_EX_Flush, misalign_err, redirect_cnt, fsm_state
  );

  modport slave (
    input  stall, PcSel, BrPC,
    output Cur_PC, PC_Four, IF_ID_Flush, ID_EX_Flush, misalign_err, redirect_cnt, fsm_state
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage program counter with taken-branch redirect, stall hold and a
// multi-cycle flush window that squashes wrong-path instructions.
module pc_redirect_ctrl #(
  parameter int PC_W         = 9,
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]      state;
  logic [2:0]      fcnt;
  logic [PC_W-1:0] cur_pc;
  logic [PC_W-1:0] pc_four;
  logic [PC_W-1:0] target;
  logic            flush;
  logic            misalign_err;
  logic [15:0]     redirect_cnt;

  assign pc_four = cur_pc + PC_W'(4);
  // Targets are forced word-aligned; any address bits above PC_W are dropped.
  assign target  = {bus.BrPC[PC_W-1:2], 2'b00};
  assign flush   = ~reset & (bus.PcSel | (state == FLUSH));

  generate
    if (PC_W < 32) begin : g_br_hi
      logic unused_br_hi;
      assign unused_br_hi = ^bus.BrPC[31:PC_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_pc <= '0;
    end else if (bus.PcSel) begin
      cur_pc <= target;
    end else if (!bus.stall) begin
      cur_pc <= pc_four;
    end
  end

  // Stall never freezes the flush window; a new redirect restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else if (bus.PcSel) begin
      if (FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        fcnt  <= 3'(FLUSH_CYCLES - 1);
      end else begin
        state <= RUN;
        fcnt  <= '0;
      end
    end else if (state == FLUSH) begin
      fcnt <= fcnt - 3'd1;
      if (fcnt == 3'd1) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      misalign_err <= bus.PcSel & (bus.BrPC[1:0] != 2'b00);
      if (bus.PcSel && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end

  assign bus.Cur_PC       = cur_pc;
  assign bus.PC_Four      = pc_four;
  assign bus.IF_ID_Flush  = flush;
  assign bus.ID_EX_Flush  = flush;
  assign bus.misalign_err = misalign_err;
  assign bus.redirect_cnt = redirect_cnt;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed test of the fetch PC controller: expected per-cycle outputs are queued
// by the driver and checked by an independent monitor.
module tb_pc_redirect_ctrl;
  localparam int PC_W = 9;
  localparam int W    = 2 * PC_W + 19;

  logic clk;
  logic reset;

  pc_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_fail;
  event         sample_ev;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    forever begin
      @(sample_ev);
      got = {bus.Cur_PC, bus.PC_Four, bus.IF_ID_Flush, bus.ID_EX_Flush,
             bus.misalign_err, bus.redirect_cnt};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sample: got %h, required an empty scoreboard", got);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s: got pc=%h pc4=%h ifid=%b idex=%b mis=%b cnt=%h, required pc=%h pc4=%h ifid=%b idex=%b mis=%b cnt=%h",
                   nm, got[W-1 -: PC_W], got[W-PC_W-1 -: PC_W], got[18], got[17], got[16], got[15:0],
                   exp[W-1 -: PC_W], exp[W-PC_W-1 -: PC_W], exp[18], exp[17], exp[16], exp[15:0]);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [PC_W-1:0] pc, input logic fl,
                          input logic mis, input logic [15:0] cnt);
    logic [PC_W-1:0] pc4;
    pc4 = pc + PC_W'(4);
    exp_q.push_back({pc, pc4, fl, fl, mis, cnt});
    name_q.push_back(nm);
    -> sample_ev;
  endtask

  // driver: one call per cycle; expected values describe that cycle, before the next edge
  task automatic step(input string nm, input logic rst, input logic st, input logic sel,
                      input logic [31:0] br, input logic [PC_W-1:0] pc, input logic fl,
                      input logic mis, input logic [15:0] cnt);
    @(negedge clk);
    reset     = rst;
    bus.stall = st;
    bus.PcSel = sel;
    bus.BrPC  = br;
    #2;
    push_exp(nm, pc, fl, mis, cnt);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.PcSel = 1'b0;
    bus.BrPC  = '0;

    //   name            rst st sel BrPC           Cur_PC  fl mis cnt
    step("rst_hold",     1, 0, 1, 32'h0000_0040, 9'h000, 0, 0, 16'd0);
    step("free0",        0, 0, 0, 32'h0,         9'h000, 0, 0, 16'd0);
    step("free4",        0, 0, 0, 32'h0,         9'h004, 0, 0, 16'd0);
    step("free8",        0, 0, 0, 32'h0,         9'h008, 0, 0, 16'd0);
    step("free12",       0, 0, 0, 32'h0,         9'h00C, 0, 0, 16'd0);
    step("br40_issue",   0, 0, 1, 32'h0000_0040, 9'h010, 1, 0, 16'd0);
    step("br40_flush2",  0, 0, 0, 32'h0,         9'h040, 1, 0, 16'd1);
    step("after_44",     0, 0, 0, 32'h0,         9'h044, 0, 0, 16'd1);
    step("after_48",     0, 0, 0, 32'h0,         9'h048, 0, 0, 16'd1);
    step("stall_br80",   0, 1, 1, 32'h0000_0080, 9'h04C, 1, 0, 16'd1);
    step("stall1_fl",    0, 1, 0, 32'h0,         9'h080, 1, 0, 16'd2);
    step("stall2",       0, 1, 0, 32'h0,         9'h080, 0, 0, 16'd2);
    step("stall3",       0, 1, 0, 32'h0,         9'h080, 0, 0, 16'd2);
    step("unstall",      0, 0, 0, 32'h0,         9'h080, 0, 0, 16'd2);
    step("br106_issue",  0, 0, 1, 32'h0000_0106, 9'h084, 1, 0, 16'd2);
    step("misalign",     0, 0, 0, 32'h0,         9'h104, 1, 1, 16'd3);
    step("trunc_issue",  0, 0, 1, 32'hFFFF_FE10, 9'h108, 1, 0, 16'd3);
    step("trunc_pc",     0, 0, 0, 32'h0,         9'h010, 1, 0, 16'd4);
    step("trunc_next",   0, 0, 0, 32'h0,         9'h014, 0, 0, 16'd4);
    step("br1f0_issue",  0, 0, 1, 32'h0000_01F0, 9'h018, 1, 0, 16'd4);
    step("rebr_in_fl",   0, 0, 1, 32'h0000_0020, 9'h1F0, 1, 0, 16'd5);
    step("rebr_flush",   0, 0, 0, 32'h0,         9'h020, 1, 0, 16'd6);
    step("rebr_done",    0, 0, 0, 32'h0,         9'h024, 0, 0, 16'd6);
    step("br1f8_issue",  0, 0, 1, 32'h0000_01F8, 9'h028, 1, 0, 16'd6);
    step("at_1f8",       0, 0, 0, 32'h0,         9'h1F8, 1, 0, 16'd7);
    step("at_1fc",       0, 0, 0, 32'h0,         9'h1FC, 0, 0, 16'd7);
    step("wrap_0",       0, 0, 0, 32'h0,         9'h000, 0, 0, 16'd7);
    step("br100_issue",  0, 0, 1, 32'h0000_0100, 9'h004, 1, 0, 16'd7);
    step("mid_flush",    0, 0, 0, 32'h0,         9'h100, 1, 0, 16'd8);

    // asynchronous reset between edges, while the flush window is open
    #1;
    reset = 1'b1;
    #1;
    push_exp("async_rst", 9'h000, 1'b0, 1'b0, 16'd0);

    step("resume0",      0, 0, 0, 32'h0,         9'h000, 0, 0, 16'd0);
    step("resume4",      0, 0, 0, 32'h0,         9'h004, 0, 0, 16'd0);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
